// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, power states and the
// command word carried through the issue FIFO.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        ACTIVE = 2'b00,
        SLEEP  = 2'b01,
        WAKE   = 2'b10
    } pwr_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } alu_cmd_t;

    // Codes 110 and 111 have no ALU operation behind them.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/alu_cmd_issue_if.sv
// Command handshake and ALU-side bus of the issue stage; the slave modport is
// the issue unit's view, the master modport the command source's view.
interface alu_cmd_issue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             In_Valid;
    logic             In_Ready;
    logic [31:0]      In_A;
    logic [31:0]      In_B;
    logic [2:0]       In_Opcode;
    logic [31:0]      Alu_A;
    logic [31:0]      Alu_B;
    logic [2:0]       Alu_Opcode;
    logic             Alu_Enable;
    logic             Sleep;
    logic             Illegal;
    logic [CNT_W-1:0] Count;

    modport slave (
        input  In_Valid, In_A, In_B, In_Opcode,
        output In_Ready, Alu_A, Alu_B, Alu_Opcode, Alu_Enable, Sleep, Illegal, Count
    );

    modport master (
        output In_Valid, In_A, In_B, In_Opcode,
        input  In_Ready, Alu_A, Alu_B, Alu_Opcode, Alu_Enable, Sleep, Illegal, Count
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with power-of-two depth; head word is visible
// combinationally on rdata whenever the FIFO is not empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  alu_cmd_t                     wdata,
    input  logic                         pop,
    output alu_cmd_t                     rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    alu_cmd_t         mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/alu_cmd_issue.sv
// ALU issue stage: buffers commands, issues one per cycle in ACTIVE, holds the
// operand registers while idle and steps through SLEEP/WAKE to save power.
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    alu_cmd_issue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IW    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WW    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    pwr_state_e       state_q, state_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [WW-1:0]    wake_q, wake_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             alu_en_q, alu_en_d;
    logic             sleep_q, sleep_d;
    logic             illegal_q, illegal_d;

    alu_cmd_t         in_cmd, head;
    logic             full, empty, accept, legal, push, pop;
    logic [CNT_W-1:0] count;

    assign bus.In_Ready = !Rst && !full;
    assign accept       = bus.In_Valid && bus.In_Ready;
    assign legal        = op_is_legal(bus.In_Opcode);
    assign push         = accept && legal;
    assign pop          = (state_q == ACTIVE) && !empty;
    assign in_cmd       = '{a: bus.In_A, b: bus.In_B, op: bus.In_Opcode};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (push),
        .wdata (in_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Operand registers only load on issue, so the ALU inputs stay quiet when idle.
    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        wake_d    = wake_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        alu_en_d  = 1'b0;
        illegal_d = accept && !legal;
        unique case (state_q)
            ACTIVE: begin
                if (!empty) begin
                    alu_a_d  = head.a;
                    alu_b_d  = head.b;
                    alu_op_d = head.op;
                    alu_en_d = 1'b1;
                    idle_d   = '0;
                end else if (push) begin
                    idle_d = '0;
                end else if (idle_q == IW'(IDLE_CYCLES - 1)) begin
                    state_d = SLEEP;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            SLEEP: begin
                if (push) begin
                    state_d = WAKE;
                    wake_d  = WW'(WAKE_CYCLES - 1);
                end
            end
            WAKE: begin
                if (wake_q == '0) state_d = ACTIVE;
                else              wake_d  = wake_q - WW'(1);
            end
            default: state_d = ACTIVE;
        endcase
        sleep_d = (state_d == SLEEP);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ACTIVE;
            idle_q    <= '0;
            wake_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= OP_ADD;
            alu_en_q  <= 1'b0;
            sleep_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            wake_q    <= wake_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_en_q  <= alu_en_d;
            sleep_q   <= sleep_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.Alu_A      = alu_a_q;
    assign bus.Alu_B      = alu_b_q;
    assign bus.Alu_Opcode = alu_op_q;
    assign bus.Alu_Enable = alu_en_q;
    assign bus.Sleep      = sleep_q;
    assign bus.Illegal    = illegal_q;
    assign bus.Count      = count;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: a queue-based model checked every cycle on the
// default-parameter DUT, plus a long-wake copy used to reach a full FIFO.
module tb_alu_cmd_issue;
    localparam int DEPTH = 4;
    localparam int IDLE  = 8;
    localparam int WAKE  = 2;
    localparam int M_RUN = 0, M_DOZE = 1, M_WAKING = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_cmd_issue_if #(.DEPTH(DEPTH)) if1 ();
    alu_cmd_issue_if #(.DEPTH(DEPTH)) if2 ();

    assign if2.In_Valid  = if1.In_Valid;
    assign if2.In_A      = if1.In_A;
    assign if2.In_B      = if1.In_B;
    assign if2.In_Opcode = if1.In_Opcode;

    alu_cmd_issue #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) u_dut (
        .Clk (clk), .Rst (rst), .bus (if1)
    );
    alu_cmd_issue #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(4)) u_full (
        .Clk (clk), .Rst (rst), .bus (if2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of u_dut
    cmd_t        mq[$];
    int          m_mode = M_RUN;
    int          m_idle = 0;
    int          m_wake = 0;
    logic [31:0] e_a = 0, e_b = 0;
    logic [2:0]  e_op = 0;
    logic        e_en = 0, e_sleep = 0, e_ill = 0;
    logic        m_acc, m_legal;
    cmd_t        m_c;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_mode = M_RUN; m_idle = 0; m_wake = 0;
                e_a = 0; e_b = 0; e_op = 0; e_en = 0; e_sleep = 0; e_ill = 0;
            end else begin
                m_acc   = if1.In_Valid && (mq.size() != DEPTH);
                m_legal = (if1.In_Opcode < 3'd6);
                e_en    = 1'b0;
                e_ill   = m_acc && !m_legal;
                if (m_mode == M_RUN) begin
                    if (mq.size() > 0) begin
                        m_c = mq.pop_front();
                        e_a = m_c.a; e_b = m_c.b; e_op = m_c.op; e_en = 1'b1;
                        m_idle = 0;
                    end else if (m_acc && m_legal) begin
                        m_idle = 0;
                    end else begin
                        m_idle++;
                        if (m_idle == IDLE) begin
                            m_mode = M_DOZE;
                            m_idle = 0;
                        end
                    end
                end else if (m_mode == M_DOZE) begin
                    if (m_acc && m_legal) begin
                        m_mode = M_WAKING;
                        m_wake = WAKE;
                    end
                end else begin
                    m_wake--;
                    if (m_wake == 0) m_mode = M_RUN;
                end
                if (m_acc && m_legal) begin
                    m_c.a = if1.In_A; m_c.b = if1.In_B; m_c.op = if1.In_Opcode;
                    mq.push_back(m_c);
                end
                e_sleep = (m_mode == M_DOZE);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("ready", {31'd0, if1.In_Ready}, {31'd0, !rst && (mq.size() != DEPTH)});
            chk("count", {29'd0, if1.Count}, mq.size());
            chk("alu_a", if1.Alu_A, e_a);
            chk("alu_b", if1.Alu_B, e_b);
            chk("alu_op", {29'd0, if1.Alu_Opcode}, {29'd0, e_op});
            chk("alu_en", {31'd0, if1.Alu_Enable}, {31'd0, e_en});
            chk("sleep", {31'd0, if1.Sleep}, {31'd0, e_sleep});
            chk("illegal", {31'd0, if1.Illegal}, {31'd0, e_ill});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if1.In_Valid = 1'b1; if1.In_A = a; if1.In_B = b; if1.In_Opcode = op;
    endtask

    task automatic idle_in();
        if1.In_Valid = 1'b0;
    endtask

    task automatic wait_sleep();
        for (int i = 0; i < 40; i++) begin
            if (if1.Sleep) break;
            tick();
        end
        chk("sleep_wait", {31'd0, if1.Sleep}, 32'd1);
    endtask

    initial begin
        if1.In_Valid = 1'b0; if1.In_A = '0; if1.In_B = '0; if1.In_Opcode = '0;
        tick(); tick();
        chk("rst_ready", {31'd0, if1.In_Ready}, 32'd0);
        chk("rst_alu_a", if1.Alu_A, 32'd0);
        chk("rst_en", {31'd0, if1.Alu_Enable}, 32'd0);
        chk("rst_count", {29'd0, if1.Count}, 32'd0);
        rst = 1'b0;

        // single command, then hold and idle into sleep
        send(32'd5, 32'd3, 3'b000); tick(); idle_in();
        chk("t1_count", {29'd0, if1.Count}, 32'd1);
        chk("t1_en_early", {31'd0, if1.Alu_Enable}, 32'd0);
        tick();
        chk("t1_en", {31'd0, if1.Alu_Enable}, 32'd1);
        chk("t1_a", if1.Alu_A, 32'd5);
        chk("t1_b", if1.Alu_B, 32'd3);
        chk("t1_op", {29'd0, if1.Alu_Opcode}, 32'd0);
        tick();
        chk("t1_en_off", {31'd0, if1.Alu_Enable}, 32'd0);
        chk("t1_a_hold", if1.Alu_A, 32'd5);
        chk("t1_b_hold", if1.Alu_B, 32'd3);
        repeat (6) tick();
        chk("t4_sleep_early", {31'd0, if1.Sleep}, 32'd0);
        tick();
        chk("t4_sleep_rise", {31'd0, if1.Sleep}, 32'd1);

        // wake with four commands; long-wake copy fills up
        for (int i = 1; i <= 4; i++) begin
            send(i, 10 + i, 3'b001); tick();
            if (i == 1) chk("t2_sleep_fall", {31'd0, if1.Sleep}, 32'd0);
            if (i == 3) chk("t2_count3", {29'd0, if1.Count}, 32'd3);
        end
        chk("t2_issue1_en", {31'd0, if1.Alu_Enable}, 32'd1);
        chk("t2_issue1_a", if1.Alu_A, 32'd1);
        chk("full_count4", {29'd0, if2.Count}, 32'd4);
        chk("full_ready", {31'd0, if2.In_Ready}, 32'd0);
        send(32'd5, 32'd15, 3'b001); tick();
        chk("t2_issue2_a", if1.Alu_A, 32'd2);
        chk("full_hold", {29'd0, if2.Count}, 32'd4);
        chk("full_pop_ready", {31'd0, if2.In_Ready}, 32'd0);
        send(32'd6, 32'd16, 3'b001); tick(); idle_in();
        chk("t2_issue3_a", if1.Alu_A, 32'd3);
        chk("full_count3", {29'd0, if2.Count}, 32'd3);
        chk("full_issue1", if2.Alu_A, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("t2_seq", if1.Alu_A, k + 2);
            chk("full_seq", if2.Alu_A, k);
            chk("full_seq_en", {31'd0, if2.Alu_Enable}, 32'd1);
        end
        tick();
        chk("full_done_en", {31'd0, if2.Alu_Enable}, 32'd0);
        chk("full_done_cnt", {29'd0, if2.Count}, 32'd0);

        // illegal opcode in ACTIVE, then in SLEEP
        send(32'd7, 32'd0, 3'b110); tick(); idle_in();
        chk("ill_act", {31'd0, if1.Illegal}, 32'd1);
        chk("ill_act_cnt", {29'd0, if1.Count}, 32'd0);
        tick();
        chk("ill_act_off", {31'd0, if1.Illegal}, 32'd0);
        wait_sleep();
        send(32'd7, 32'd0, 3'b111); tick(); idle_in();
        chk("ill_slp", {31'd0, if1.Illegal}, 32'd1);
        chk("ill_slp_sleep", {31'd0, if1.Sleep}, 32'd1);
        tick();
        chk("ill_slp_off", {31'd0, if1.Illegal}, 32'd0);
        chk("ill_slp_sleep2", {31'd0, if1.Sleep}, 32'd1);

        // legal accept at idle count 7 keeps the unit awake
        send(32'd9, 32'd1, 3'b010); tick(); idle_in();
        tick(); tick(); tick();
        chk("t4_wake_issue", if1.Alu_A, 32'd9);
        repeat (7) tick();
        send(32'd10, 32'd2, 3'b011); tick(); idle_in();
        chk("t4_no_sleep", {31'd0, if1.Sleep}, 32'd0);
        tick();
        chk("t4_issue10", if1.Alu_A, 32'd10);
        repeat (7) tick();
        chk("t4_sleep_pre", {31'd0, if1.Sleep}, 32'd0);
        tick();
        chk("t4_sleep_again", {31'd0, if1.Sleep}, 32'd1);

        // reset in the middle of a burst
        for (int i = 21; i <= 24; i++) begin
            send(i, 0, 3'b100); tick();
        end
        chk("t6_cnt3", {29'd0, if1.Count}, 32'd3);
        chk("t6_en", {31'd0, if1.Alu_Enable}, 32'd1);
        rst = 1'b1; #1;
        chk("t6_rst_a", if1.Alu_A, 32'd0);
        chk("t6_rst_en", {31'd0, if1.Alu_Enable}, 32'd0);
        chk("t6_rst_cnt", {29'd0, if1.Count}, 32'd0);
        idle_in();
        tick(); rst = 1'b0;
        tick(); tick();
        chk("t6_post_en", {31'd0, if1.Alu_Enable}, 32'd0);
        chk("t6_post_cnt", {29'd0, if1.Count}, 32'd0);
        send(32'd11, 32'd4, 3'b101); tick(); idle_in();
        chk("t6_new_cnt", {29'd0, if1.Count}, 32'd1);
        tick();
        chk("t6_new_en", {31'd0, if1.Alu_Enable}, 32'd1);
        chk("t6_new_a", if1.Alu_A, 32'd11);
        chk("t6_new_op", {29'd0, if1.Alu_Opcode}, 32'd5);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Upstream issue stage for the 32-bit ALU.
- Accepts operand/opcode commands through a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's A, B, Opcode and Enable inputs, one command per cycle.
- Power management: holds the ALU operands stable while idle (operand isolation) and requests a sleep state after a run of idle cycles.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- IDLE_CYCLES, 8: consecutive idle ACTIVE cycles before entering SLEEP; ≥1.
- WAKE_CYCLES, 2: settle cycles in WAKE before issue resumes; ≥1.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- In_Valid  in  1  command valid.
- In_Ready  out  1  command ready; a command is accepted when In_Valid && In_Ready at a rising edge.
- In_A  in  32  operand A.
- In_B  in  32  operand B.
- In_Opcode  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not.
- Alu_A  out  32  registered operand A to the ALU.
- Alu_B  out  32  registered operand B to the ALU.
- Alu_Opcode  out  3  registered opcode to the ALU.
- Alu_Enable  out  1  registered; high for exactly one cycle per issued command.
- Sleep  out  1  registered power-down request to the clock/power controller.
- Illegal  out  1  registered one-cycle pulse when an illegal opcode is accepted.
- Count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (asynchronous):
  - FIFO emptied; Count=0.
  - Alu_A, Alu_B = 0; Alu_Opcode = 000; Alu_Enable = 0; Sleep = 0; Illegal = 0.
  - State = ACTIVE; idle counter = 0; wake counter = 0.
  - Reset mid-operation discards every buffered command; nothing stale is issued after release.
- In_Ready = !Rst && (Count != DEPTH), in every state.
  - No pass-through: when full, In_Ready stays low even in a cycle that pops.
- Illegal opcodes (110, 111):
  - Handshake still completes, but the command is not written to the FIFO.
  - Illegal = 1 in the following cycle only; Count unchanged.
  - Does not wake from SLEEP and does not clear the idle counter.
- Legal accept: command written at the FIFO tail. A push and a pop in the same cycle are both honoured.
- State ACTIVE:
  - If FIFO non-empty at an edge: pop the head, register it onto Alu_A/B/Opcode, and set Alu_Enable=1 for that cycle.
  - Otherwise Alu_Enable=0 and Alu_A/B/Opcode hold their last values (no toggling).
  - Issue order is strictly FIFO.
- Latency: a command accepted into an empty FIFO at edge N appears with Alu_Enable=1 after edge N+1. Back-to-back accepts give a throughput of 1/cycle.
- Idle counter (ACTIVE only):
  - Increments on each edge where the FIFO is empty and there is no legal accept.
  - Cleared on a legal accept or when the FIFO is non-empty.
  - When the counter equals IDLE_CYCLES-1 and the cycle is still idle: next state SLEEP, Sleep=1.
- State SLEEP:
  - Alu_Enable=0 and Sleep=1; accepts continue.
  - A legal accept moves to WAKE at that edge: Sleep=0, wake counter loaded with WAKE_CYCLES-1.
- State WAKE:
  - No issue (Alu_Enable=0); accepts continue until full.
  - Wake counter decrements each edge; at 0 the next state is ACTIVE, and issue starts on the first ACTIVE edge.
- Rst asserted in any state returns to the reset values immediately (asynchronous).

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101.
  - Opcode-legal function.
  - Power-state encoding ACTIVE=2'b00, SLEEP=2'b01, WAKE=2'b10.
  - Command struct {a[31:0], b[31:0], op[2:0]} (67 bits).
- One sub-module: alu_cmd_fifo.
  - Synchronous FIFO, DEPTH entries, 67-bit word.
  - Asynchronous active-high reset; outputs full, empty and count.
- FSM, idle/wake counters and output registers live in alu_cmd_issue.

Test Plan:
- Rst pulse, then accept {A=5, B=3, op=000} at edge 0 -> Alu_Enable=1 after edge 1 with Alu_A=5, Alu_B=3, Alu_Opcode=000. Alu_Enable=0 after edge 2, and Alu_A stays 5 and Alu_B stays 3.
- Idle for 8 cycles -> Sleep=1. Then push 4 legal commands (A=1..4) on consecutive edges:
  - Sleep falls after the first accept; Count reaches 3 during WAKE.
  - ACTIVE resumes 2 cycles after the first accept; issued Alu_A sequence is 1,2,3,4 with no gaps.
  - A 5th push while Count=4 sees In_Ready=0.
- Accept op=110 (A=7) in ACTIVE and then in SLEEP -> Illegal pulses one cycle each time; Count stays 0; Alu_Enable never rises; Sleep stays 1 in SLEEP.
- Issue a command, then stay idle -> Sleep rises exactly after the 8th idle edge. A legal accept at idle count 7 clears the counter, and no SLEEP entry occurs.
- Full FIFO with simultaneous pop in ACTIVE -> In_Ready=0 that cycle; Count goes DEPTH -> DEPTH-1; no command is lost or duplicated.
- Rst asserted while Count=3 and Alu_Enable=1 -> outputs zero immediately; after release Count=0, Alu_Enable stays 0, state ACTIVE, and the first new command issues with the 1-cycle latency.
